// File: rtl/wavegen_i2s_if.sv
// Configuration inputs and DAC pin outputs of the waveform generator / I2S transmitter.
// PHASE_W must match the PHASE_W of the attached wavegen_i2s_tx.
interface wavegen_i2s_if #(
  parameter int PHASE_W = 32
);
  logic [PHASE_W-1:0] inc_l;
  logic [PHASE_W-1:0] inc_r;
  logic [1:0]         mode_l;
  logic [1:0]         mode_r;
  logic [3:0]         att_l;
  logic [3:0]         att_r;
  logic               mclk_dac;
  logic               sclk_dac;
  logic               lrck_dac;
  logic               sdata_dac;
  logic               frame_stb;

  modport master (
    output inc_l, inc_r, mode_l, mode_r, att_l, att_r,
    input  mclk_dac, sclk_dac, lrck_dac, sdata_dac, frame_stb
  );

  modport slave (
    input  inc_l, inc_r, mode_l, mode_r, att_l, att_r,
    output mclk_dac, sclk_dac, lrck_dac, sdata_dac, frame_stb
  );
endinterface

// File: rtl/wavegen_i2s_tx.sv
// Two-channel phase-accumulator waveform generator feeding an I2S serializer (64 SCLK per frame).
// Define ATTEN_EN to enable per-channel arithmetic right-shift attenuation of the samples.
module wavegen_i2s_tx #(
  parameter int DATA_W   = 24,
  parameter int PHASE_W  = 32,
  parameter int SCLK_DIV = 2
) (
  input logic          clk,
  input logic          rst,
  wavegen_i2s_if.slave bus
);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic               mclk_q, mclk_d;
  logic               sclk_q, sclk_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               stb_q, stb_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [PHASE_W-1:0] phase_q [2];
  logic [PHASE_W-1:0] phase_d [2];
  logic [DATA_W-1:0]  smp_q [2];
  logic [DATA_W-1:0]  smp_d [2];

  logic               div_wrap, fall_evt, frame_start;
  logic [4:0]         slot_pos;
  logic [DATA_W-1:0]  slot_word;
  logic [DATA_W-1:0]  t, u;
  logic signed [DATA_W-1:0] raw;
  logic [PHASE_W-1:0] inc_s [2];
  logic [1:0]         mode_s [2];

  assign inc_s[0]  = bus.inc_l;
  assign inc_s[1]  = bus.inc_r;
  assign mode_s[0] = bus.mode_l;
  assign mode_s[1] = bus.mode_r;

`ifdef ATTEN_EN
  logic [3:0] att_s [2];
  assign att_s[0] = bus.att_l;
  assign att_s[1] = bus.att_r;
`else
  logic unused_att;
  assign unused_att = ^{bus.att_l, bus.att_r};
`endif

  always_comb begin
    mclk_d      = ~mclk_q;
    div_wrap    = (div_cnt_q == DIV_W'(SCLK_DIV - 1));
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    sclk_d      = sclk_q ^ div_wrap;
    fall_evt    = div_wrap & sclk_q;
    bit_cnt_d   = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;
    frame_start = fall_evt & (bit_cnt_q == 6'd63);
    stb_d       = frame_start;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;

    // Position 0 is the one-bit I2S delay; the word occupies 1..DATA_W, zero padding after.
    slot_pos  = bit_cnt_d[4:0];
    slot_word = (bit_cnt_d[5] ? smp_q[1] : smp_q[0]) << (slot_pos - 5'd1);
    if (fall_evt) begin
      lrck_d  = bit_cnt_d[5];
      sdata_d = (slot_pos != 5'd0) && (int'(slot_pos) <= DATA_W) && slot_word[DATA_W-1];
    end

    phase_d = phase_q;
    smp_d   = smp_q;
    t       = '0;
    u       = '0;
    raw     = '0;
    for (int ch = 0; ch < 2; ch++) begin
      t = phase_q[ch][PHASE_W-1 -: DATA_W];
      // Folding the lower phase bits on the MSB gives a triangle with no overflow at the turns.
      u = phase_q[ch][PHASE_W-2 -: DATA_W] ^ {DATA_W{phase_q[ch][PHASE_W-1]}};
      case (mode_s[ch])
        2'd0:    raw = {~u[DATA_W-1], u[DATA_W-2:0]};
        2'd1:    raw = {~t[DATA_W-1], t[DATA_W-2:0]};
        2'd2:    raw = phase_q[ch][PHASE_W-1] ? {1'b1, {(DATA_W-2){1'b0}}, 1'b1}
                                              : {1'b0, {(DATA_W-1){1'b1}}};
        default: raw = '0;
      endcase
`ifdef ATTEN_EN
      raw = raw >>> att_s[ch];
`endif
      if (frame_start) begin
        smp_d[ch]   = raw;
        phase_d[ch] = phase_q[ch] + inc_s[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_q     <= 1'b0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      stb_q      <= 1'b0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      phase_q[0] <= '0;
      phase_q[1] <= '0;
      smp_q[0]   <= '0;
      smp_q[1]   <= '0;
    end else begin
      mclk_q    <= mclk_d;
      sclk_q    <= sclk_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      stb_q     <= stb_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      smp_q     <= smp_d;
    end
  end

  assign bus.mclk_dac  = mclk_q;
  assign bus.sclk_dac  = sclk_q;
  assign bus.lrck_dac  = lrck_q;
  assign bus.sdata_dac = sdata_q;
  assign bus.frame_stb = stb_q;
endmodule
